demux_stream: RTL
=================

Name: demux_stream

Overview:
- Parametrised 1-to-N stream demultiplexer: routes DATA_W-bit beats from one valid/ready input to one of N_OUT valid/ready outputs, or to all outputs in broadcast mode.
- Packet-aware. The select is latched on the first beat and held until the last beat.
- One register slice per output. Out-of-range selects are dropped and counted.
- Sits between a single producer and N consumer channels, and replaces the fixed 1-to-8 combinational demux.

Parameters:
- DATA_W, 8, beat data width.
- N_OUT, 8, number of output channels (2..16; need not be a power of 2).
- SEL_W, 4, select width. Must satisfy 2**SEL_W >= N_OUT.
- CNT_W, 8, width of the dropped-packet counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset. Synchronous, active-low.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat ready (combinational).
- s_data  in  DATA_W  input beat data.
- s_sel  in  SEL_W  destination index. Sampled on the first beat of a packet only.
- s_bcast  in  1  broadcast packet. Sampled on the first beat only.
- s_last  in  1  final beat of packet.
- m_valid  out  N_OUT  per-output valid.
- m_ready  in  N_OUT  per-output ready.
- m_data  out  N_OUT*DATA_W  flattened data; channel k occupies bits [k*DATA_W +: DATA_W].
- m_last  out  N_OUT  per-output last.
- err_sel  out  1  one-cycle pulse when a packet with s_sel >= N_OUT starts.
- drop_cnt  out  CNT_W  count of dropped packets, saturating at all-ones.
- busy  out  1  high while FSM is in PKT or DROP.

Behaviour:
- Reset (rst_n low at a clk edge):
  - m_valid=0, m_data=0, m_last=0, err_sel=0, drop_cnt=0, FSM=IDLE, latched sel/bcast=0.
  - s_ready=0 while rst_n is low.
  - Reset mid-packet discards the packet silently. drop_cnt is not incremented.
- Transfer: a beat transfers when s_valid && s_ready at a clk edge. The same rule applies per output with m_valid[k] && m_ready[k].
- Slot k is free when !m_valid[k] || m_ready[k]. This gives same-cycle drain and refill and sustains 1 beat/clk per channel.
- Target set:
  - IDLE: from s_sel/s_bcast.
  - PKT: from the latched sel/bcast.
  - Broadcast: the target is all N_OUT slots.
- s_ready:
  - PKT/IDLE with valid target: AND of free over the target set.
  - IDLE with s_sel >= N_OUT, or DROP: 1 (sink).
  - s_ready must not depend on s_data.
- Accepted beat to a valid target: target slot(s) load s_data and s_last, and m_valid is set the next cycle (latency 1 clk). Non-target slots are untouched.
- Broadcast is all-or-nothing. No output receives the beat until every slot is free.
- FSM states:
  - IDLE, accept with valid sel and !s_last: latch sel/bcast, go to PKT.
  - IDLE, accept with valid sel and s_last: single-beat packet, stay in IDLE.
  - IDLE, accept with sel >= N_OUT: err_sel=1 for one cycle, drop_cnt += 1 (saturating). Go to DROP if !s_last, else stay in IDLE.
  - PKT: s_sel/s_bcast ignored. Accept with s_last goes to IDLE.
  - DROP: beats consumed and discarded. No err_sel, no count. Accept with s_last goes to IDLE.
- A new packet may start in the cycle after its predecessor's last beat. No bubble is required.
- drop_cnt holds at 2**CNT_W-1 once reached.
- m_data/m_last of a slot hold their value while m_valid is low or m_ready is low. Data is stable under backpressure.

Decomposition:
- Shared package demux_pkg:
  - FSM state encoding constants ST_IDLE, ST_PKT, ST_DROP.
  - Default width constants.
  - Function clog2 used to check SEL_W.
- Sub-module demux_slot: one-entry valid/ready register slice (DATA_W+1 bits). Instantiated N_OUT times by generate loop, with load, free, m_valid, m_ready, data and last.
- Top: FSM, target decode, s_ready AND-reduction, error counter.

Test Plan:
- Sweep: N_OUT=8, m_ready all 1, single-beat packets s_sel=0..7 with s_data=8'hA0+i, one per clk. Required: m_valid[i] pulses exactly 1 clk after each accept with m_data[i]=8'hA0+i, and no other channel asserts.
- Packet lock: 4-beat packet with sel=3 where s_sel changes to 5 on beats 2-4. Required: all 4 beats appear on channel 3 with m_last[3] only on beat 4, channel 5 stays idle, and busy=1 from after beat 1 until after beat 4.
- Backpressure: m_ready[2]=0, send 2 beats to sel=2. Required: first beat held on m_data[2] and s_ready=0 on the second. After m_ready[2]=1 for 2 clks, both beats are delivered in order with no loss or duplication.
- Broadcast: s_bcast=1 with m_ready[6]=0. Required: s_ready=0 and no m_valid rises. Release m_ready[6]; required: all 8 m_valid rise together with identical data.
- Error: N_OUT=6, 3-beat packet with s_sel=7. Required: s_ready=1 throughout, err_sel pulses once, drop_cnt goes 0→1, no m_valid asserts. Repeating 300 times saturates drop_cnt at 255.
- Reset mid-packet: drive rst_n=0 on beat 2 of a sel=1 packet. Required: next clk m_valid=0, FSM=IDLE, drop_cnt unchanged. Next packet with sel=4 routes correctly.

Source files
------------

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared state encoding, default widths and helpers for demux_stream
package demux_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_PKT  = 2'd1;
  localparam state_t ST_DROP = 2'd2;

  localparam int DATA_W_DEF = 8;
  localparam int N_OUT_DEF  = 8;
  localparam int SEL_W_DEF  = 4;
  localparam int CNT_W_DEF  = 8;

  // Smallest r with 2**r >= value; used to confirm the select is wide enough
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry valid/ready register slice for a single output channel
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              free,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  // A slot can take a new beat when empty or when its current beat leaves this cycle
  assign free = !m_valid || m_ready;

  // Load has priority over drain so the slot refills in the same cycle it empties
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= s_data;
      m_last  <= s_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_stream.sv
// rtl/demux_stream.sv - packet-aware 1-to-N stream demultiplexer with broadcast and drop counting
module demux_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_OUT  = N_OUT_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  input  logic [SEL_W-1:0]        s_sel,
  input  logic                    s_bcast,
  input  logic                    s_last,
  output logic [N_OUT-1:0]        m_valid,
  input  logic [N_OUT-1:0]        m_ready,
  output logic [N_OUT*DATA_W-1:0] m_data,
  output logic [N_OUT-1:0]        m_last,
  output logic                    err_sel,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic                    busy
);

  if (SEL_W < clog2(N_OUT)) begin : g_bad_sel_w
    $error("demux_stream: SEL_W too narrow to address N_OUT channels");
  end

  state_t state, state_nxt;

  logic [SEL_W-1:0] sel_q;
  logic             bcast_q;
  logic [SEL_W-1:0] cur_sel;
  logic             cur_bcast;
  logic             sel_bad;
  logic [N_OUT-1:0] target;
  logic [N_OUT-1:0] free;
  logic [N_OUT-1:0] load;
  logic             sink;
  logic             accept;
  logic             latch;
  logic             err_hit;

  // Target set: live select on the first beat, latched select for the rest of a packet
  always_comb begin
    cur_sel   = (state == ST_PKT) ? sel_q   : s_sel;
    cur_bcast = (state == ST_PKT) ? bcast_q : s_bcast;
    sel_bad   = !cur_bcast && (int'(cur_sel) >= N_OUT);
    target    = '0;
    for (int k = 0; k < N_OUT; k++) begin
      target[k] = cur_bcast || (cur_sel == SEL_W'(k));
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: leave IDLE on a non-final first beat, return on any accepted last beat
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && !s_last) state_nxt = sel_bad ? ST_DROP : ST_PKT;
      ST_PKT,
      ST_DROP: if (accept && s_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: sink unroutable packets, otherwise wait until every targeted slot is free
  always_comb begin
    sink    = 1'b0;
    s_ready = 1'b0;
    accept  = 1'b0;
    load    = '0;
    err_hit = 1'b0;
    latch   = 1'b0;
    case (state)
      ST_IDLE: sink = sel_bad;
      ST_DROP: sink = 1'b1;
      default: sink = 1'b0;
    endcase
    if (rst_n) s_ready = sink ? 1'b1 : &(free | ~target);
    accept = s_valid && s_ready;
    if (accept && !sink) load = target;
    err_hit = accept && (state == ST_IDLE) && sel_bad;
    latch   = accept && (state == ST_IDLE) && !sel_bad && !s_last;
  end

  // Packet destination is captured on the first beat and held until the last
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q   <= '0;
      bcast_q <= 1'b0;
    end else if (latch) begin
      sel_q   <= s_sel;
      bcast_q <= s_bcast;
    end
  end

  // Error pulse and saturating count of dropped packets
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sel  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      err_sel <= err_hit;
      if (err_hit && (drop_cnt != {CNT_W{1'b1}})) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign busy = (state != ST_IDLE);

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load[k]),
      .s_data (s_data),
      .s_last (s_last),
      .free   (free[k]),
      .m_valid(m_valid[k]),
      .m_ready(m_ready[k]),
      .m_data (m_data[k*DATA_W +: DATA_W]),
      .m_last (m_last[k])
    );
  end

endmodule
